// File: rtl/uart_msg_decoder_if.sv
// Receive-FIFO handshake between the UART rx FIFO (master) and the game message decoder (slave).
// The FIFO presents its head byte and empty flag, and the decoder returns a one-cycle pop strobe.
interface uart_msg_decoder_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;

  modport master (output rx_empty, output r_data, input rd_uart);
  modport slave  (input rx_empty, input r_data, output rd_uart);
endinterface

// File: rtl/uart_msg_decoder.sv
// Pops game-link bytes from the UART rx FIFO and decodes 'R' (remote ready) and 'L' (remote lost)
// into sticky flags, event pulses, a game-start pulse, a bad-byte counter and a link-alive indicator.
module uart_msg_decoder #(
  parameter logic [7:0]  MSG_READY      = 8'h52,
  parameter logic [7:0]  MSG_LOST       = 8'h4C,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                clk,
  input  logic                rst,
  uart_msg_decoder_if.slave   rx,
  input  logic                local_ready,
  input  logic                clr,
  output logic                remote_ready,
  output logic                remote_lost,
  output logic                remote_lost_flag,
  output logic                game_start,
  output logic [7:0]          err_cnt,
  output logic [7:0]          last_char,
  output logic                link_alive
);

  localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, POP, DECODE, SETTLE} state_t;

  state_t      state;
  logic [7:0]  byte_reg;
  logic [31:0] link_timer;
  logic [31:0] link_timer_nxt;
  logic        seen_valid;
  logic        seen_valid_nxt;
  logic        is_ready;
  logic        is_lost;
  logic        is_bad;

  // Classify the latched byte while in DECODE; the link timer only restarts on recognised messages.
  always_comb begin
    is_ready       = 1'b0;
    is_lost        = 1'b0;
    is_bad         = 1'b0;
    link_timer_nxt = link_timer;
    seen_valid_nxt = seen_valid;
    if (state == DECODE) begin
      is_ready = (byte_reg == MSG_READY);
      is_lost  = (byte_reg == MSG_LOST);
      is_bad   = (byte_reg != MSG_READY) && (byte_reg != MSG_LOST);
    end
    if (is_ready || is_lost) begin
      link_timer_nxt = '0;
      seen_valid_nxt = 1'b1;
    end else if (link_timer < TIMEOUT) begin
      link_timer_nxt = link_timer + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      byte_reg         <= 8'h00;
      rx.rd_uart       <= 1'b0;
      remote_ready     <= 1'b0;
      remote_lost      <= 1'b0;
      remote_lost_flag <= 1'b0;
      game_start       <= 1'b0;
      err_cnt          <= 8'h00;
      last_char        <= 8'h00;
      link_alive       <= 1'b0;
      link_timer       <= '0;
      seen_valid       <= 1'b0;
    end else begin
      rx.rd_uart <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx.rx_empty) begin
            byte_reg   <= rx.r_data;
            rx.rd_uart <= 1'b1;
            state      <= POP;
          end
        end
        POP:     state <= DECODE;
        DECODE: begin
          last_char <= byte_reg;
          state     <= SETTLE;
        end
        default: state <= IDLE;
      endcase

      // An 'L' or a clear in the same cycle blocks the start pulse; consuming 'R' clears remote_ready.
      game_start  <= remote_ready && local_ready && !clr && !is_lost;
      remote_lost <= is_lost && !clr;
      if (clr || is_lost || (remote_ready && local_ready)) begin
        remote_ready <= 1'b0;
      end else if (is_ready) begin
        remote_ready <= 1'b1;
      end

      if (clr) begin
        remote_lost_flag <= 1'b0;
      end else if (is_lost) begin
        remote_lost_flag <= 1'b1;
      end

      if (clr) begin
        err_cnt <= 8'h00;
      end else if (is_bad && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      link_timer <= link_timer_nxt;
      seen_valid <= seen_valid_nxt;
      link_alive <= seen_valid_nxt && (link_timer_nxt < TIMEOUT);
    end
  end

endmodule
